// File: rtl/yutorina_id_stage_pkg.sv
// Shared ISA and pipeline definitions for the yutorina decode stage.
// Holds opcodes, control encodings, the registered ID control bundle and decode helpers.
package yutorina_id_stage_pkg;

    localparam int unsigned GprAddrW = 5;
    localparam int unsigned PcW      = 30;
    localparam int unsigned DataW    = 32;

    // Pipeline enables and GPR write enables are active-low.
    localparam logic EnableN  = 1'b0;
    localparam logic DisableN = 1'b1;

    localparam logic [5:0] OpAndR = 6'h00;
    localparam logic [5:0] OpAndI = 6'h01;
    localparam logic [5:0] OpOrR  = 6'h02;
    localparam logic [5:0] OpOrI  = 6'h03;
    localparam logic [5:0] OpAddR = 6'h04;
    localparam logic [5:0] OpAddI = 6'h05;
    localparam logic [5:0] OpSubR = 6'h06;
    localparam logic [5:0] OpSubI = 6'h07;
    localparam logic [5:0] OpXorR = 6'h08;
    localparam logic [5:0] OpXorI = 6'h09;
    localparam logic [5:0] OpShlR = 6'h0A;
    localparam logic [5:0] OpShlI = 6'h0B;
    localparam logic [5:0] OpJr   = 6'h0C;
    localparam logic [5:0] OpBe   = 6'h10;
    localparam logic [5:0] OpBne  = 6'h11;
    localparam logic [5:0] OpLdw  = 6'h16;
    localparam logic [5:0] OpStw  = 6'h17;
    localparam logic [5:0] OpTrap = 6'h3E;

    typedef enum logic [3:0] {
        AluNop = 4'd0,
        AluAnd = 4'd1,
        AluOr  = 4'd2,
        AluAdd = 4'd3,
        AluSub = 4'd4,
        AluXor = 4'd5,
        AluShl = 4'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        MemNone = 2'd0,
        MemLdw  = 2'd1,
        MemStw  = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        ExpNone    = 2'd0,
        ExpIllegal = 2'd1,
        ExpTrap    = 2'd2
    } exp_code_e;

    typedef struct packed {
        alu_op_e               alu_op;
        logic [DataW-1:0]      alu_in_0;
        logic [DataW-1:0]      alu_in_1;
        mem_op_e               mem_op;
        logic [DataW-1:0]      mem_wr_data;
        logic [GprAddrW-1:0]   dst_addr;
        logic                  gpr_we_n;
        exp_code_e             exp_code;
    } id_ctrl_t;

    localparam id_ctrl_t CtrlReset = '{
        alu_op:      AluNop,
        alu_in_0:    '0,
        alu_in_1:    '0,
        mem_op:      MemNone,
        mem_wr_data: '0,
        dst_addr:    '0,
        gpr_we_n:    DisableN,
        exp_code:    ExpNone
    };

    function automatic logic [DataW-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // ALU R/I opcode pairs occupy 6'h00..6'h0B; bits [3:1] select the operation.
    function automatic alu_op_e alu_of(input logic [2:0] pair);
        unique case (pair)
            3'd0:    return AluAnd;
            3'd1:    return AluOr;
            3'd2:    return AluAdd;
            3'd3:    return AluSub;
            3'd4:    return AluXor;
            3'd5:    return AluShl;
            default: return AluNop;
        endcase
    endfunction

endpackage

// File: rtl/yutorina_id_stage_decoder.sv
// Combinational decode: GPR read, EX/MEM forwarding, branch resolution and
// load-use hazard detection for the instruction currently presented by fetch.
module yutorina_id_stage_decoder
    import yutorina_id_stage_pkg::*;
#(
    parameter bit FwdEn = 1'b1
) (
    input  logic [29:0] if_pc_i,
    input  logic [31:0] if_insn_i,
    input  logic        if_en_n_i,
    output logic [4:0]  gpr_rd_addr_0_o,
    output logic [4:0]  gpr_rd_addr_1_o,
    input  logic [31:0] gpr_rd_data_0_i,
    input  logic [31:0] gpr_rd_data_1_i,
    input  logic        ex_en_n_i,
    input  logic        ex_gpr_we_n_i,
    input  logic [4:0]  ex_dst_addr_i,
    input  logic [31:0] ex_fwd_data_i,
    input  logic        ex_is_load_i,
    input  logic        mem_en_n_i,
    input  logic        mem_gpr_we_n_i,
    input  logic [4:0]  mem_dst_addr_i,
    input  logic [31:0] mem_fwd_data_i,
    output logic        br_taken_o,
    output logic [29:0] br_addr_o,
    output logic        ld_hazard_o,
    output id_ctrl_t    ctrl_o
);

    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [31:0] imm_s, ra_data, rb_data;
    logic        ex_wr, mem_wr;
    logic        uses_ra, uses_rb, is_be, is_bne, is_jr;

    assign op    = if_insn_i[31:26];
    assign ra    = if_insn_i[25:21];
    assign rb    = if_insn_i[20:16];
    assign rc    = if_insn_i[15:11];
    assign imm_s = sext16(if_insn_i[15:0]);

    assign gpr_rd_addr_0_o = ra;
    assign gpr_rd_addr_1_o = rb;

    // EX holds the younger result, so it wins over MEM for the same register.
    assign ex_wr  = FwdEn && !ex_en_n_i && !ex_gpr_we_n_i;
    assign mem_wr = FwdEn && !mem_en_n_i && !mem_gpr_we_n_i;

    assign ra_data = (ex_wr && ex_dst_addr_i == ra)   ? ex_fwd_data_i  :
                     (mem_wr && mem_dst_addr_i == ra) ? mem_fwd_data_i : gpr_rd_data_0_i;
    assign rb_data = (ex_wr && ex_dst_addr_i == rb)   ? ex_fwd_data_i  :
                     (mem_wr && mem_dst_addr_i == rb) ? mem_fwd_data_i : gpr_rd_data_1_i;

    always_comb begin
        ctrl_o = '{
            alu_op:      AluNop,
            alu_in_0:    ra_data,
            alu_in_1:    rb_data,
            mem_op:      MemNone,
            mem_wr_data: rb_data,
            dst_addr:    '0,
            gpr_we_n:    DisableN,
            exp_code:    ExpNone
        };
        uses_ra = 1'b1;
        uses_rb = 1'b0;
        is_be   = 1'b0;
        is_bne  = 1'b0;
        is_jr   = 1'b0;
        unique case (op)
            OpAndR, OpOrR, OpAddR, OpSubR, OpXorR, OpShlR: begin
                ctrl_o.alu_op   = alu_of(op[3:1]);
                ctrl_o.dst_addr = rc;
                ctrl_o.gpr_we_n = EnableN;
                uses_rb         = 1'b1;
            end
            OpAndI, OpOrI, OpAddI, OpSubI, OpXorI, OpShlI: begin
                ctrl_o.alu_op   = alu_of(op[3:1]);
                ctrl_o.alu_in_1 = imm_s;
                ctrl_o.dst_addr = rb;
                ctrl_o.gpr_we_n = EnableN;
            end
            OpLdw: begin
                ctrl_o.alu_op   = AluAdd;
                ctrl_o.alu_in_1 = imm_s;
                ctrl_o.mem_op   = MemLdw;
                ctrl_o.dst_addr = rb;
                ctrl_o.gpr_we_n = EnableN;
            end
            OpStw: begin
                ctrl_o.alu_op   = AluAdd;
                ctrl_o.alu_in_1 = imm_s;
                ctrl_o.mem_op   = MemStw;
                uses_rb         = 1'b1;
            end
            OpBe: begin
                is_be   = 1'b1;
                uses_rb = 1'b1;
            end
            OpBne: begin
                is_bne  = 1'b1;
                uses_rb = 1'b1;
            end
            OpJr:   is_jr = 1'b1;
            OpTrap: begin
                ctrl_o.exp_code = ExpTrap;
                uses_ra         = 1'b0;
            end
            default: ctrl_o.exp_code = ExpIllegal;
        endcase
    end

    assign ld_hazard_o = !if_en_n_i && !ex_en_n_i && ex_is_load_i &&
                         ((uses_ra && ex_dst_addr_i == ra) || (uses_rb && ex_dst_addr_i == rb));

    assign br_taken_o = !if_en_n_i && !ld_hazard_o &&
                        ((is_be && ra_data == rb_data) || (is_bne && ra_data != rb_data) || is_jr);
    assign br_addr_o  = is_jr ? ra_data[31:2] : if_pc_i + imm_s[29:0];

endmodule

// File: rtl/yutorina_id_stage.sv
// Decode stage top: combinational decoder plus the id_* pipeline registers feeding EX.
// Register priority is reset, flush, stall, bubble (hazard or no valid insn), then decode.
module yutorina_id_stage
    import yutorina_id_stage_pkg::*;
#(
    parameter bit FwdEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [29:0] if_pc_i,
    input  logic [31:0] if_insn_i,
    input  logic        if_en_n_i,
    output logic [4:0]  gpr_rd_addr_0_o,
    output logic [4:0]  gpr_rd_addr_1_o,
    input  logic [31:0] gpr_rd_data_0_i,
    input  logic [31:0] gpr_rd_data_1_i,
    input  logic        ex_en_n_i,
    input  logic        ex_gpr_we_n_i,
    input  logic [4:0]  ex_dst_addr_i,
    input  logic [31:0] ex_fwd_data_i,
    input  logic        ex_is_load_i,
    input  logic        mem_en_n_i,
    input  logic        mem_gpr_we_n_i,
    input  logic [4:0]  mem_dst_addr_i,
    input  logic [31:0] mem_fwd_data_i,
    output logic        br_taken_o,
    output logic [29:0] br_addr_o,
    output logic        ld_hazard_o,
    output logic [29:0] id_pc_o,
    output logic        id_en_n_o,
    output logic [3:0]  id_alu_op_o,
    output logic [31:0] id_alu_in_0_o,
    output logic [31:0] id_alu_in_1_o,
    output logic [1:0]  id_mem_op_o,
    output logic [31:0] id_mem_wr_data_o,
    output logic [4:0]  id_dst_addr_o,
    output logic        id_gpr_we_n_o,
    output logic [1:0]  id_exp_code_o
);

    id_ctrl_t    dec_ctrl;
    id_ctrl_t    ctrl_d, ctrl_q;
    logic [29:0] id_pc_d, id_pc_q;
    logic        id_en_n_d, id_en_n_q;

    yutorina_id_stage_decoder #(
        .FwdEn (FwdEn)
    ) u_decoder (
        .if_pc_i         (if_pc_i),
        .if_insn_i       (if_insn_i),
        .if_en_n_i       (if_en_n_i),
        .gpr_rd_addr_0_o (gpr_rd_addr_0_o),
        .gpr_rd_addr_1_o (gpr_rd_addr_1_o),
        .gpr_rd_data_0_i (gpr_rd_data_0_i),
        .gpr_rd_data_1_i (gpr_rd_data_1_i),
        .ex_en_n_i       (ex_en_n_i),
        .ex_gpr_we_n_i   (ex_gpr_we_n_i),
        .ex_dst_addr_i   (ex_dst_addr_i),
        .ex_fwd_data_i   (ex_fwd_data_i),
        .ex_is_load_i    (ex_is_load_i),
        .mem_en_n_i      (mem_en_n_i),
        .mem_gpr_we_n_i  (mem_gpr_we_n_i),
        .mem_dst_addr_i  (mem_dst_addr_i),
        .mem_fwd_data_i  (mem_fwd_data_i),
        .br_taken_o      (br_taken_o),
        .br_addr_o       (br_addr_o),
        .ld_hazard_o     (ld_hazard_o),
        .ctrl_o          (dec_ctrl)
    );

    always_comb begin
        id_pc_d   = id_pc_q;
        id_en_n_d = id_en_n_q;
        ctrl_d    = ctrl_q;
        if (flush_i) begin
            id_en_n_d       = DisableN;
            ctrl_d.gpr_we_n = DisableN;
        end else if (!stall_i) begin
            if (ld_hazard_o || if_en_n_i) begin
                id_en_n_d       = DisableN;
                ctrl_d.gpr_we_n = DisableN;
            end else begin
                id_pc_d   = if_pc_i;
                id_en_n_d = EnableN;
                ctrl_d    = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_pc_q   <= '0;
            id_en_n_q <= DisableN;
            ctrl_q    <= CtrlReset;
        end else begin
            id_pc_q   <= id_pc_d;
            id_en_n_q <= id_en_n_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign id_pc_o          = id_pc_q;
    assign id_en_n_o        = id_en_n_q;
    assign id_alu_op_o      = ctrl_q.alu_op;
    assign id_alu_in_0_o    = ctrl_q.alu_in_0;
    assign id_alu_in_1_o    = ctrl_q.alu_in_1;
    assign id_mem_op_o      = ctrl_q.mem_op;
    assign id_mem_wr_data_o = ctrl_q.mem_wr_data;
    assign id_dst_addr_o    = ctrl_q.dst_addr;
    assign id_gpr_we_n_o    = ctrl_q.gpr_we_n;
    assign id_exp_code_o    = ctrl_q.exp_code;

endmodule

// File: tb/tb_yutorina_id_stage.sv
// Directed bench for yutorina_id_stage: decode, forwarding, load-use hazard,
// branches, stall/flush priority, illegal/trap codes and asynchronous reset.
module tb_yutorina_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en_n;
    logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
    logic        ex_en_n, ex_gpr_we_n, ex_is_load;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_fwd_data;
    logic        mem_en_n, mem_gpr_we_n;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_fwd_data;
    logic        br_taken, ld_hazard;
    logic [29:0] br_addr, id_pc;
    logic        id_en_n, id_gpr_we_n;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
    logic [1:0]  id_mem_op, id_exp_code;
    logic [4:0]  id_dst_addr;

    logic [31:0] gpr [32];
    int          errors = 0;
    int          checks = 0;

    assign gpr_rd_data_0 = gpr[gpr_rd_addr_0];
    assign gpr_rd_data_1 = gpr[gpr_rd_addr_1];

    always #5 clk = ~clk;

    yutorina_id_stage dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .stall_i          (stall),
        .flush_i          (flush),
        .if_pc_i          (if_pc),
        .if_insn_i        (if_insn),
        .if_en_n_i        (if_en_n),
        .gpr_rd_addr_0_o  (gpr_rd_addr_0),
        .gpr_rd_addr_1_o  (gpr_rd_addr_1),
        .gpr_rd_data_0_i  (gpr_rd_data_0),
        .gpr_rd_data_1_i  (gpr_rd_data_1),
        .ex_en_n_i        (ex_en_n),
        .ex_gpr_we_n_i    (ex_gpr_we_n),
        .ex_dst_addr_i    (ex_dst_addr),
        .ex_fwd_data_i    (ex_fwd_data),
        .ex_is_load_i     (ex_is_load),
        .mem_en_n_i       (mem_en_n),
        .mem_gpr_we_n_i   (mem_gpr_we_n),
        .mem_dst_addr_i   (mem_dst_addr),
        .mem_fwd_data_i   (mem_fwd_data),
        .br_taken_o       (br_taken),
        .br_addr_o        (br_addr),
        .ld_hazard_o      (ld_hazard),
        .id_pc_o          (id_pc),
        .id_en_n_o        (id_en_n),
        .id_alu_op_o      (id_alu_op),
        .id_alu_in_0_o    (id_alu_in_0),
        .id_alu_in_1_o    (id_alu_in_1),
        .id_mem_op_o      (id_mem_op),
        .id_mem_wr_data_o (id_mem_wr_data),
        .id_dst_addr_o    (id_dst_addr),
        .id_gpr_we_n_o    (id_gpr_we_n),
        .id_exp_code_o    (id_exp_code)
    );

    function automatic logic [31:0] r_insn(input logic [5:0] op, input logic [4:0] ra,
                                           input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, rc, 11'b0};
    endfunction

    function automatic logic [31:0] i_insn(input logic [5:0] op, input logic [4:0] ra,
                                           input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        if_pc = '0; if_insn = '0; if_en_n = 1'b1;
        ex_en_n = 1'b1; ex_gpr_we_n = 1'b1; ex_dst_addr = '0; ex_fwd_data = '0; ex_is_load = 1'b0;
        mem_en_n = 1'b1; mem_gpr_we_n = 1'b1; mem_dst_addr = '0; mem_fwd_data = '0;
        for (int i = 0; i < 32; i++) gpr[i] = '0;
        tick(); tick();
        checks++; if (id_en_n !== 1'b1) begin errors++; $display("FAIL reset_en: got %b want 1", id_en_n); end
        checks++; if (id_gpr_we_n !== 1'b1) begin errors++; $display("FAIL reset_we: got %b want 1", id_gpr_we_n); end
        checks++; if (id_exp_code !== 2'd0) begin errors++; $display("FAIL reset_exp: got %0d want 0", id_exp_code); end
        checks++; if (id_pc !== 30'd0 || id_alu_in_0 !== 32'd0) begin errors++; $display("FAIL reset_data: pc %h in0 %h want 0", id_pc, id_alu_in_0); end
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_br: got %b want 0", br_taken); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        gpr[1] = 32'd10; gpr[2] = 32'hCAFE_0002;
        if_pc = 30'h40; if_insn = i_insn(6'h05, 5'd1, 5'd2, 16'd5); if_en_n = 1'b0;
        #1;
        checks++; if (gpr_rd_addr_0 !== 5'd1 || gpr_rd_addr_1 !== 5'd2) begin errors++; $display("FAIL addi_rdaddr: got %0d,%0d want 1,2", gpr_rd_addr_0, gpr_rd_addr_1); end
        tick();
        checks++; if (id_alu_in_0 !== 32'd10 || id_alu_in_1 !== 32'd5) begin errors++; $display("FAIL addi_ops: got %h,%h want a,5", id_alu_in_0, id_alu_in_1); end
        checks++; if (id_dst_addr !== 5'd2 || id_gpr_we_n !== 1'b0 || id_en_n !== 1'b0) begin errors++; $display("FAIL addi_ctrl: dst %0d we %b en %b want 2,0,0", id_dst_addr, id_gpr_we_n, id_en_n); end
        checks++; if (id_alu_op !== 4'd3 || id_pc !== 30'h40) begin errors++; $display("FAIL addi_op_pc: op %0d pc %h want 3,40", id_alu_op, id_pc); end
        // STW r2 -> M[r1+4]
        if_insn = i_insn(6'h17, 5'd1, 5'd2, 16'd4);
        tick();
        checks++; if (id_mem_op !== 2'd2 || id_gpr_we_n !== 1'b1 || id_mem_wr_data !== 32'hCAFE_0002 || id_alu_in_1 !== 32'd4) begin errors++; $display("FAIL stw: mem %0d we %b wd %h in1 %h want 2,1,cafe0002,4", id_mem_op, id_gpr_we_n, id_mem_wr_data, id_alu_in_1); end
    endtask

    task automatic test_forward();
        gpr[1] = 32'd1;
        ex_en_n = 1'b0; ex_gpr_we_n = 1'b0; ex_dst_addr = 5'd1; ex_fwd_data = 32'd7;
        mem_en_n = 1'b0; mem_gpr_we_n = 1'b0; mem_dst_addr = 5'd1; mem_fwd_data = 32'd9;
        if_insn = r_insn(6'h04, 5'd1, 5'd1, 5'd3);
        tick();
        checks++; if (id_alu_in_0 !== 32'd7 || id_alu_in_1 !== 32'd7 || id_dst_addr !== 5'd3) begin errors++; $display("FAIL fwd_ex: got %h,%h dst %0d want 7,7,3", id_alu_in_0, id_alu_in_1, id_dst_addr); end
        ex_en_n = 1'b1;
        tick();
        checks++; if (id_alu_in_0 !== 32'd9 || id_alu_in_1 !== 32'd9) begin errors++; $display("FAIL fwd_mem: got %h,%h want 9,9", id_alu_in_0, id_alu_in_1); end
        mem_gpr_we_n = 1'b1;
        tick();
        checks++; if (id_alu_in_0 !== 32'd1) begin errors++; $display("FAIL fwd_none: got %h want 1", id_alu_in_0); end
        mem_en_n = 1'b1;
    endtask

    task automatic test_ld_hazard();
        gpr[4] = 32'h44;
        ex_en_n = 1'b0; ex_gpr_we_n = 1'b0; ex_is_load = 1'b1; ex_dst_addr = 5'd4; ex_fwd_data = 32'hDEAD;
        if_insn = i_insn(6'h3E, 5'd4, 5'd4, 16'd0);
        #1;
        checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL haz_trap: got %b want 0", ld_hazard); end
        if_insn = i_insn(6'h05, 5'd0, 5'd4, 16'd1);
        #1;
        checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL haz_idst: got %b want 0", ld_hazard); end
        if_insn = r_insn(6'h10, 5'd4, 5'd4, 5'd0);
        #1;
        checks++; if (ld_hazard !== 1'b1 || br_taken !== 1'b0) begin errors++; $display("FAIL haz_be: haz %b br %b want 1,0", ld_hazard, br_taken); end
        if_insn = r_insn(6'h04, 5'd0, 5'd4, 5'd5);
        #1;
        checks++; if (ld_hazard !== 1'b1 || br_taken !== 1'b0) begin errors++; $display("FAIL haz_addr: haz %b br %b want 1,0", ld_hazard, br_taken); end
        tick();
        checks++; if (id_en_n !== 1'b1 || id_gpr_we_n !== 1'b1) begin errors++; $display("FAIL haz_bubble: en %b we %b want 1,1", id_en_n, id_gpr_we_n); end
        ex_en_n = 1'b1; ex_is_load = 1'b0;
        #1;
        checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL haz_clear: got %b want 0", ld_hazard); end
        tick();
        checks++; if (id_en_n !== 1'b0 || id_alu_in_1 !== 32'h44 || id_dst_addr !== 5'd5) begin errors++; $display("FAIL haz_resume: en %b in1 %h dst %0d want 0,44,5", id_en_n, id_alu_in_1, id_dst_addr); end
    endtask

    task automatic test_branch();
        gpr[1] = 32'd5; gpr[2] = 32'd5; gpr[7] = 32'h0000_1234;
        if_pc = 30'h100; if_insn = i_insn(6'h10, 5'd1, 5'd2, 16'hFFFE);
        #1;
        checks++; if (br_taken !== 1'b1 || br_addr !== 30'h0FE) begin errors++; $display("FAIL be_eq: br %b addr %h want 1,0fe", br_taken, br_addr); end
        tick();
        checks++; if (id_en_n !== 1'b0 || id_gpr_we_n !== 1'b1) begin errors++; $display("FAIL be_regs: en %b we %b want 0,1", id_en_n, id_gpr_we_n); end
        gpr[2] = 32'd6;
        #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL be_ne: got %b want 0", br_taken); end
        if_insn = i_insn(6'h11, 5'd1, 5'd2, 16'h0010);
        #1;
        checks++; if (br_taken !== 1'b1 || br_addr !== 30'h110) begin errors++; $display("FAIL bne: br %b addr %h want 1,110", br_taken, br_addr); end
        if_pc = 30'h0; if_insn = i_insn(6'h11, 5'd1, 5'd2, 16'hFFFE);
        #1;
        checks++; if (br_addr !== 30'h3FFF_FFFE) begin errors++; $display("FAIL br_wrap: got %h want 3ffffffe", br_addr); end
        if_insn = i_insn(6'h0C, 5'd7, 5'd0, 16'd0);
        #1;
        checks++; if (br_taken !== 1'b1 || br_addr !== 30'h48D) begin errors++; $display("FAIL jr: br %b addr %h want 1,48d", br_taken, br_addr); end
        if_en_n = 1'b1;
        #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_invalid: got %b want 0", br_taken); end
        if_en_n = 1'b0;
    endtask

    task automatic test_stall_flush();
        gpr[1] = 32'd10;
        if_pc = 30'h40; if_insn = i_insn(6'h05, 5'd1, 5'd2, 16'd5);
        tick();
        stall = 1'b1; if_pc = 30'h80; if_insn = i_insn(6'h05, 5'd1, 5'd6, 16'd99);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (id_dst_addr !== 5'd2 || id_alu_in_1 !== 32'd5 || id_pc !== 30'h40 || id_en_n !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: dst %0d in1 %h pc %h en %b want 2,5,40,0", i, id_dst_addr, id_alu_in_1, id_pc, id_en_n); end
        end
        flush = 1'b1;
        tick();
        checks++; if (id_en_n !== 1'b1 || id_gpr_we_n !== 1'b1 || id_dst_addr !== 5'd2) begin errors++; $display("FAIL flush_stall: en %b we %b dst %0d want 1,1,2", id_en_n, id_gpr_we_n, id_dst_addr); end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_illegal_reset();
        if_pc = 30'h200; if_insn = i_insn(6'h3F, 5'd0, 5'd0, 16'd0);
        tick();
        checks++; if (id_exp_code !== 2'd1 || id_gpr_we_n !== 1'b1 || id_en_n !== 1'b0) begin errors++; $display("FAIL illegal: exp %0d we %b en %b want 1,1,0", id_exp_code, id_gpr_we_n, id_en_n); end
        if_insn = i_insn(6'h3E, 5'd0, 5'd0, 16'd0);
        tick();
        checks++; if (id_exp_code !== 2'd2 || id_gpr_we_n !== 1'b1) begin errors++; $display("FAIL trap: exp %0d we %b want 2,1", id_exp_code, id_gpr_we_n); end
        #2;
        rst_n = 1'b0; if_en_n = 1'b1;
        #1;
        checks++; if (id_en_n !== 1'b1 || id_exp_code !== 2'd0 || id_pc !== 30'd0 || id_alu_op !== 4'd0) begin errors++; $display("FAIL async_rst: en %b exp %0d pc %h op %0d want 1,0,0,0", id_en_n, id_exp_code, id_pc, id_alu_op); end
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL rst_br: got %b want 0", br_taken); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_forward();
        test_ld_hazard();
        test_branch();
        test_stall_flush();
        test_illegal_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
